// File: rtl/counter_step_decoder.sv
// counter_step_decoder: recovers direction and step size of an up/down step counter from its
// observed count word, with lock detection and a saturating count of invalid transitions.
module counter_step_decoder #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int ERRW     = 8
) (
    input  logic             clk_i,
    input  logic             nrst_i,
    input  logic [WIDTH-1:0] cnt_i,
    input  logic             cnt_vld_i,
    output logic             down_o,
    output logic             step_o,
    output logic             locked_o,
    output logic             err_o,
    output logic [ERRW-1:0]  err_cnt_o
);
    localparam int RW = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {EMPTY, ACQ, LOCK} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [RW-1:0]    run_q, run_d, run_nx;
    logic             down_q, down_d, step_q, step_d;
    logic             locked_q, locked_d, err_q, err_d;
    logic [ERRW-1:0]  err_cnt_q, err_cnt_d;
    logic [WIDTH-1:0] delta;
    logic             up1, up2, dn1, dn2, valid, cls_dn, cls_st, same;

    // Modulo subtraction in WIDTH bits makes counter wrap-around decode naturally.
    assign delta  = cnt_i - prev_q;
    assign up1    = delta == WIDTH'(1);
    assign up2    = delta == WIDTH'(2);
    assign dn1    = delta == {WIDTH{1'b1}};
    assign dn2    = delta == {{(WIDTH-1){1'b1}}, 1'b0};
    assign valid  = up1 | up2 | dn1 | dn2;
    assign cls_dn = dn1 | dn2;
    assign cls_st = up2 | dn2;
    assign same   = (cls_dn == down_q) && (cls_st == step_q);
    assign run_nx = (same && run_q != '0) ? run_q + RW'(1) : RW'(1);

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        run_d     = run_q;
        down_d    = down_q;
        step_d    = step_q;
        locked_d  = locked_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        if (cnt_vld_i) begin
            prev_d = cnt_i;
            case (state_q)
                EMPTY: state_d = ACQ;
                ACQ: begin
                    if (valid) begin
                        down_d = cls_dn;
                        step_d = cls_st;
                        run_d  = run_nx;
                        if (run_nx == RW'(LOCK_CNT)) begin
                            state_d  = LOCK;
                            locked_d = 1'b1;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                LOCK: begin
                    if (valid && !same) begin
                        down_d   = cls_dn;
                        step_d   = cls_st;
                        run_d    = RW'(1);
                        locked_d = 1'b0;
                        state_d  = ACQ;
                    end else if (!valid) begin
                        err_d     = 1'b1;
                        err_cnt_d = err_cnt_q + ERRW'(err_cnt_q != '1);
                        locked_d  = 1'b0;
                        run_d     = '0;
                        state_d   = ACQ;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            state_q   <= EMPTY;
            prev_q    <= '0;
            run_q     <= '0;
            down_q    <= 1'b0;
            step_q    <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            run_q     <= run_d;
            down_q    <= down_d;
            step_q    <= step_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign down_o    = down_q;
    assign step_o    = step_q;
    assign locked_o  = locked_q;
    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;
endmodule

// File: tb/tb_counter_step_decoder.sv
// tb_counter_step_decoder: directed scenarios plus random samples, checked against a
// delta-history model of the decoder (ERRW=2 so saturation is reachable).
module tb_counter_step_decoder;
    localparam int W = 4, L = 3, E = 2, M = 16, EMAX = 3;

    logic         clk = 1'b0, nrst = 1'b0, vld = 1'b0;
    logic [W-1:0] cnt = '0;
    logic         down, step, locked, err;
    logic [E-1:0] err_cnt;
    int           n_chk = 0, n_err = 0;

    // Model: run = number of consecutive identical valid deltas (capped at L).
    int m_have, m_prev, m_run, m_down, m_step, m_locked, m_err, m_ecnt;

    counter_step_decoder #(.WIDTH(W), .LOCK_CNT(L), .ERRW(E)) dut (
        .clk_i(clk), .nrst_i(nrst), .cnt_i(cnt), .cnt_vld_i(vld),
        .down_o(down), .step_o(step), .locked_o(locked), .err_o(err), .err_cnt_o(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit v, input int c);
        int d, cd, cs;
        bit ok;
        m_err = 0;
        if (!r) begin
            m_have = 0; m_prev = 0; m_run = 0; m_down = 0; m_step = 0; m_locked = 0; m_ecnt = 0;
        end else if (v) begin
            if (m_have) begin
                d  = (c - m_prev + M) % M;
                ok = (d == 1) || (d == 2) || (d == M - 1) || (d == M - 2);
                cd = (d >= M - 2) ? 1 : 0;
                cs = (d == 2 || d == M - 2) ? 1 : 0;
                if (ok) begin
                    m_run  = (m_run > 0 && cd == m_down && cs == m_step) ? ((m_run + 1 > L) ? L : m_run + 1) : 1;
                    m_down = cd;
                    m_step = cs;
                    m_locked = (m_run == L) ? 1 : 0;
                end else begin
                    if (m_locked != 0) begin
                        m_err  = 1;
                        m_ecnt = (m_ecnt < EMAX) ? m_ecnt + 1 : EMAX;
                    end
                    m_run = 0;
                    m_locked = 0;
                end
            end
            m_have = 1;
            m_prev = c;
        end
    endtask

    task automatic tick(input bit r, input bit v, input int c, input string tag);
        nrst = r; vld = v; cnt = W'(c);
        @(posedge clk);
        model(r, v, c);
        #1;
        chk({tag, ".down"}, 32'(down), 32'(m_down));
        chk({tag, ".step"}, 32'(step), 32'(m_step));
        chk({tag, ".locked"}, 32'(locked), 32'(m_locked));
        chk({tag, ".err"}, 32'(err), 32'(m_err));
        chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_ecnt));
    endtask

    task automatic seq(input int a, input int b, input int c, input int d, input string tag);
        tick(1, 1, a, tag); tick(1, 1, b, tag); tick(1, 1, c, tag); tick(1, 1, d, tag);
    endtask

    initial begin
        int p, k, dsel;
        tick(0, 1, 7, "reset");
        chk("reset.zero", {down, step, locked, err, 28'(err_cnt)}, 32'd0);
        // 1: UP1 locks after third identical delta
        tick(1, 1, 0, "s1");
        seq(1, 2, 3, 4, "s1");
        chk("s1.locked_const", 32'(locked), 32'd1);
        // 2: DN2 across wrap
        tick(0, 0, 0, "s2rst");
        seq(2, 0, 14, 12, "s2");
        chk("s2.dn2_const", {down, step, locked}, 32'd7);
        // 3: invalid while locked
        tick(0, 0, 0, "s3rst");
        seq(2, 3, 4, 5, "s3");
        tick(1, 1, 9, "s3.bad");
        chk("s3.err_const", {err, locked, 2'(err_cnt)}, 32'h9);
        tick(1, 0, 0, "s3.pulse_end");
        chk("s3.err_one_cycle", 32'(err), 32'd0);
        // 4: UP1 lock then switch to UP2
        tick(0, 0, 0, "s4rst");
        seq(1, 2, 3, 4, "s4");
        tick(1, 1, 6, "s4.switch");
        chk("s4.drop", {locked, step}, 32'd1);
        tick(1, 1, 8, "s4");
        tick(1, 1, 10, "s4.relock");
        chk("s4.relock_const", {locked, step, err}, 32'd6);
        // 5: gaps between samples freeze state
        tick(0, 0, 0, "s5rst");
        tick(1, 1, 0, "s5"); tick(1, 0, 9, "s5gap"); tick(1, 1, 1, "s5"); tick(1, 0, 5, "s5gap");
        tick(1, 0, 8, "s5gap"); tick(1, 1, 2, "s5"); tick(1, 0, 0, "s5gap"); tick(1, 1, 3, "s5");
        chk("s5.locked_const", 32'(locked), 32'd1);
        // 6: err_cnt saturation, then reset mid-lock
        tick(0, 0, 0, "s6rst");
        p = 0;
        tick(1, 1, p, "s6");
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 3; j++) begin p = (p + 1) % M; tick(1, 1, p, "s6"); end
            p = (p + 5) % M;
            tick(1, 1, p, "s6.bad");
        end
        chk("s6.sat_const", 32'(err_cnt), 32'd3);
        for (int j = 0; j < 3; j++) begin p = (p + 1) % M; tick(1, 1, p, "s6"); end
        tick(0, 1, (p + 5) % M, "s6.midrst");
        chk("s6.rst_const", {down, step, locked, err, 28'(err_cnt)}, 32'd0);
        // Random: mostly steady deltas with occasional class changes, gaps, junk and resets
        p = 0; dsel = 1;
        for (int i = 0; i < 400; i++) begin
            k = int'($urandom_range(0, 19));
            if (k == 0) dsel = int'($urandom_range(0, 3));
            if (k == 1) begin
                tick(0, 1, int'($urandom_range(0, M - 1)), "rnd.rst");
            end else if (k < 4) begin
                tick(1, 0, int'($urandom_range(0, M - 1)), "rnd.gap");
            end else begin
                p = (k == 4) ? int'($urandom_range(0, M - 1))
                             : (p + ((dsel == 0) ? 1 : (dsel == 1) ? 2 : (dsel == 2) ? M - 1 : M - 2)) % M;
                tick(1, 1, p, "rnd");
            end
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
